// File: rtl/dram_store_buf_pkg.sv
// Shared defaults for the posted-write store buffer between MEM and the data RAM.
package dram_store_buf_pkg;
    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 14;
    localparam int SB_DW    = 32;
    // Store-to-load forwarding enable; off makes loads read DRAM directly.
    localparam bit CON_ENABLE = 1'b1;

    function automatic int sb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/dram_store_buf_if.sv
// MEM-side request/forward signals and DRAM-side drain handshake of the store buffer.
interface dram_store_buf_if
    import dram_store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
);
    localparam int CW = sb_cnt_w(DEPTH);

    logic          mem_dram_we_i;
    logic          mem_is_load_i;
    logic [AW-1:0] mem_dram_adr_i;
    logic [DW-1:0] mem_dram_wd_i;
    logic          sb_stall_o;
    logic          dram_we_o;
    logic [AW-1:0] dram_adr_o;
    logic [DW-1:0] dram_wd_o;
    logic          dram_ready_i;
    logic [DW-1:0] dram_rd_i;
    logic [DW-1:0] mem_dram_rd_o;
    logic          sb_empty_o;
    logic [CW-1:0] sb_count_o;

    modport slave (
        input  mem_dram_we_i, mem_is_load_i, mem_dram_adr_i, mem_dram_wd_i,
               dram_ready_i, dram_rd_i,
        output sb_stall_o, dram_we_o, dram_adr_o, dram_wd_o,
               mem_dram_rd_o, sb_empty_o, sb_count_o
    );

    modport master (
        output mem_dram_we_i, mem_is_load_i, mem_dram_adr_i, mem_dram_wd_i,
               dram_ready_i, dram_rd_i,
        input  sb_stall_o, dram_we_o, dram_adr_o, dram_wd_o,
               mem_dram_rd_o, sb_empty_o, sb_count_o
    );
endinterface

// File: rtl/dram_store_buf_sb_fwd_match.sv
// Age-ordered address match: picks the youngest valid entry holding the load address.
module sb_fwd_match
    import dram_store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic [DEPTH-1:0][AW-1:0]     ent_adr,
    input  logic [DEPTH-1:0]             ent_vld,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic [AW-1:0]                ld_adr,
    output logic                         hit,
    output logic [$clog2(DEPTH)-1:0]     win_idx
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] match;
    logic [PW-1:0]    idx;

    for (genvar e = 0; e < DEPTH; e++) begin : g_cmp
        assign match[e] = ent_vld[e] && (ent_adr[e] == ld_adr);
    end

    // Walk oldest to youngest so the last hit taken is the youngest one.
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && match[idx]) begin
                hit     = 1'b1;
                win_idx = idx;
            end
        end
    end
endmodule

// File: rtl/dram_store_buf.sv
// Posted-write store buffer: FIFO of committed stores drained to DRAM, with load forwarding.
module dram_store_buf
    import dram_store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dram_store_buf_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] adr_q;
    logic [DEPTH-1:0][DW-1:0] wd_q;
    logic [DEPTH-1:0]         vld_q;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;

    logic          full, enq, deq, fwd_hit;
    logic [PW-1:0] fwd_idx;

    // Stall and enqueue use start-of-cycle count only: a same-cycle drain never frees a slot.
    assign full = (count == CW'(DEPTH));
    assign enq  = sb.mem_dram_we_i && !full;
    assign deq  = (count != '0) && sb.dram_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            adr_q  <= '0;
            wd_q   <= '0;
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                adr_q[wr_ptr] <= sb.mem_dram_adr_i;
                wd_q[wr_ptr]  <= sb.mem_dram_wd_i;
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (deq) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (enq && !deq)      count <= count + CW'(1);
            else if (!enq && deq) count <= count - CW'(1);
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd (
        .ent_adr (adr_q),
        .ent_vld (vld_q),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .ld_adr  (sb.mem_dram_adr_i),
        .hit     (fwd_hit),
        .win_idx (fwd_idx)
    );

    assign sb.sb_stall_o    = sb.mem_dram_we_i && full;
    assign sb.dram_we_o     = (count != '0);
    assign sb.dram_adr_o    = adr_q[rd_ptr];
    assign sb.dram_wd_o     = wd_q[rd_ptr];
    // A head entry draining this cycle still forwards; DRAM only updates at the edge.
    assign sb.mem_dram_rd_o = (CON_ENABLE && sb.mem_is_load_i && fwd_hit) ? wd_q[fwd_idx]
                                                                           : sb.dram_rd_i;
    assign sb.sb_empty_o    = (count == '0);
    assign sb.sb_count_o    = count;
endmodule

// File: tb/tb_dram_store_buf.sv
// Directed + random bench for dram_store_buf with a queue-based reference of buffered stores.
module tb_dram_store_buf;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
    } st_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    st_t  q[$];
    int   mcount = 0;

    dram_store_buf_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    dram_store_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .sb      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic ld, input logic [AW-1:0] adr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic rdy);
        bus.mem_dram_we_i  = we;
        bus.mem_is_load_i  = ld;
        bus.mem_dram_adr_i = adr;
        bus.mem_dram_wd_i  = wd;
        bus.dram_rd_i      = rd;
        bus.dram_ready_i   = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge rst_n) begin
        q.delete();
        mcount = 0;
    end

    // Reference model: checks every output each cycle, then advances the queue like the buffer.
    always @(negedge clk) begin
        if (rst_n) begin
            logic          acc, drn;
            logic [DW-1:0] exp_rd;
            acc = bus.mem_dram_we_i && (mcount != DEPTH);
            drn = (mcount != 0) && bus.dram_ready_i;
            chk("m_stall", bus.sb_stall_o, bus.mem_dram_we_i && (mcount == DEPTH));
            chk("m_we",    bus.dram_we_o,  mcount != 0);
            chk("m_count", bus.sb_count_o, mcount);
            chk("m_empty", bus.sb_empty_o, mcount == 0);
            exp_rd = bus.dram_rd_i;
            if (bus.mem_is_load_i)
                for (int i = 0; i < q.size(); i++)
                    if (q[i].adr == bus.mem_dram_adr_i) exp_rd = q[i].wd;
            chk("m_fwd", bus.mem_dram_rd_o, exp_rd);
            if (drn) begin
                st_t h;
                h = q.pop_front();
                chk("m_drain_adr", bus.dram_adr_o, h.adr);
                chk("m_drain_wd",  bus.dram_wd_o,  h.wd);
                mcount--;
            end
            if (acc) begin
                st_t n;
                n.adr = bus.mem_dram_adr_i;
                n.wd  = bus.mem_dram_wd_i;
                q.push_back(n);
                mcount++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, '0, '0, 0);
        // Reset state
        @(negedge clk);
        chk("rst_we",    bus.dram_we_o,  0);
        chk("rst_adr",   bus.dram_adr_o, 0);
        chk("rst_wd",    bus.dram_wd_o,  0);
        chk("rst_empty", bus.sb_empty_o, 1);
        chk("rst_count", bus.sb_count_o, 0);
        chk("rst_stall", bus.sb_stall_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single store appears on the drain port next cycle
        drive(1, 0, 14'h0010, 32'hDEADBEEF, '0, 0);
        cyc();
        drive(0, 0, '0, '0, '0, 0);
        @(negedge clk);
        chk("t1_we",    bus.dram_we_o,  1);
        chk("t1_adr",   bus.dram_adr_o, 14'h0010);
        chk("t1_wd",    bus.dram_wd_o,  32'hDEADBEEF);
        chk("t1_count", bus.sb_count_o, 1);

        // 2: fill, stall on the fifth store, accept after one drain cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 14'h0100 + 14'(i), 32'hA0 + 32'(i), '0, 0);
            cyc();
        end
        drive(1, 0, 14'h0104, 32'hA4, '0, 0);
        @(negedge clk);
        chk("t2_stall", bus.sb_stall_o, 1);
        chk("t2_full",  bus.sb_count_o, 4);
        cyc();
        drive(1, 0, 14'h0104, 32'hA4, '0, 1);
        @(negedge clk);
        chk("t2_stall_drain", bus.sb_stall_o, 1);
        cyc();
        drive(1, 0, 14'h0104, 32'hA4, '0, 0);
        @(negedge clk);
        chk("t2_accept", bus.sb_stall_o, 0);
        cyc();
        drive(0, 0, '0, '0, '0, 0);
        @(negedge clk);
        chk("t2_count4", bus.sb_count_o, 4);
        drive(0, 0, '0, '0, '0, 1);
        repeat (5) cyc();
        chk("t2_drained", bus.sb_empty_o, 1);

        // 3: youngest duplicate wins
        drive(1, 0, 14'h0020, 32'h11111111, '0, 0);
        cyc();
        drive(0, 1, 14'h0020, '0, 32'h0, 0);
        @(negedge clk);
        chk("t3_fwd_one", bus.mem_dram_rd_o, 32'h11111111);
        cyc();
        drive(1, 0, 14'h0020, 32'h22222222, '0, 0);
        cyc();
        drive(0, 1, 14'h0020, '0, 32'h0, 0);
        @(negedge clk);
        chk("t3_fwd_young", bus.mem_dram_rd_o, 32'h22222222);
        cyc();

        // 4: miss passes DRAM data; non-load passes DRAM data
        drive(0, 1, 14'h0030, '0, 32'hCAFEF00D, 0);
        @(negedge clk);
        chk("t4_miss", bus.mem_dram_rd_o, 32'hCAFEF00D);
        cyc();
        drive(0, 0, 14'h0020, '0, 32'h00000055, 0);
        @(negedge clk);
        chk("t4_noload", bus.mem_dram_rd_o, 32'h00000055);
        cyc();
        drive(0, 0, '0, '0, '0, 1);
        repeat (2) cyc();

        // 5: forward from the entry draining this cycle
        drive(1, 0, 14'h0040, 32'h12345678, '0, 0);
        cyc();
        drive(0, 1, 14'h0040, '0, 32'h0, 1);
        @(negedge clk);
        chk("t5_fwd_drain", bus.mem_dram_rd_o, 32'h12345678);
        cyc();
        drive(0, 0, '0, '0, '0, 0);
        @(negedge clk);
        chk("t5_empty", bus.sb_empty_o, 1);
        cyc();

        // Random mix: wraparound, concurrent enqueue/drain, stalls, forwarding
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 3));
            drive(r < 2, r == 2, 14'($urandom_range(0, 5)), $urandom, $urandom,
                  $urandom_range(0, 1) == 1);
            cyc();
        end
        drive(0, 0, '0, '0, '0, 1);
        repeat (DEPTH + 1) cyc();

        // 6: asynchronous reset with pending stores discards them
        drive(0, 0, '0, '0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 14'h0200 + 14'(i), 32'hB0 + 32'(i), '0, 0);
            cyc();
        end
        drive(0, 0, '0, '0, '0, 0);
        @(negedge clk);
        chk("t6_pending", bus.sb_count_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we",    bus.dram_we_o,  0);
        chk("t6_count", bus.sb_count_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_drain", bus.dram_we_o, 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
